// File: rtl/dbp_buffer_ctrl.sv
// Decoder-side DBP block buffer sequencer: expands zero runs and frames each block as
// one base word followed by DATA_W+1 DBPs, counting blocks per job.
module dbp_buffer_ctrl #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BLOCK_SIZE = 8,
    parameter int unsigned ZRUN_W     = 4,
    parameter int unsigned BLK_CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [BLK_CNT_W-1:0] num_blocks_i,
    input  logic                 clr_i,
    input  logic [1:0]           sym_type_i,
    input  logic [DATA_W-1:0]    sym_data_i,
    input  logic                 sym_vld_i,
    output logic                 sym_rdy_o,
    output logic [DATA_W-1:0]    buf_data_o,
    output logic                 buf_push_o,
    output logic                 buf_vld_o,
    input  logic                 buf_rdy_i,
    output logic                 buf_clr_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int unsigned CW = $clog2(DATA_W + 2);
    localparam logic [1:0] SymBase = 2'b00;
    localparam logic [1:0] SymDbp  = 2'b01;
    localparam logic [1:0] SymZrun = 2'b10;
    // DBP field is left-aligned; bits below it are not part of the plane.
    localparam logic [DATA_W-1:0] DbpMask = {DATA_W{1'b1}} << (DATA_W - BLOCK_SIZE + 1);

    typedef enum logic [1:0] {StIdle, StBase, StDbp, StZrun} state_e;

    state_e               state_q;
    logic [CW-1:0]        dbp_cnt_q;
    logic [ZRUN_W-1:0]    zrem_q;
    logic [BLK_CNT_W-1:0] blk_cnt_q;
    logic                 busy_q, done_q, err_q;

    logic                 accept;
    logic                 blk_end;
    logic [CW-1:0]        rem_after;
    logic [ZRUN_W-1:0]    zlen;

    always_comb begin
        sym_rdy_o  = 1'b0;
        buf_push_o = 1'b0;
        buf_data_o = '0;
        case (state_q)
            StBase, StDbp: sym_rdy_o = buf_rdy_i & ~clr_i;
            default:       sym_rdy_o = 1'b0;
        endcase
        accept = sym_vld_i & sym_rdy_o;
        case (state_q)
            StBase: begin
                if (accept && sym_type_i == SymBase) begin
                    buf_push_o = 1'b1;
                    buf_data_o = sym_data_i;
                end
            end
            StDbp: begin
                if (accept && sym_type_i == SymDbp) begin
                    buf_push_o = 1'b1;
                    buf_data_o = sym_data_i & DbpMask;
                end else if (accept && sym_type_i == SymZrun) begin
                    buf_push_o = 1'b1;
                end
            end
            StZrun:  buf_push_o = buf_rdy_i & ~clr_i;
            default: buf_push_o = 1'b0;
        endcase
        blk_end   = buf_push_o && (state_q != StBase) && (dbp_cnt_q == CW'(DATA_W));
        buf_vld_o = blk_end;
        buf_clr_o = clr_i;
        // DBP slots still free after the current push
        rem_after = CW'(DATA_W) - dbp_cnt_q;
        zlen      = sym_data_i[ZRUN_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q   <= StIdle;
            dbp_cnt_q <= '0;
            zrem_q    <= '0;
            blk_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (num_blocks_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q   <= StBase;
                            blk_cnt_q <= num_blocks_i;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                StBase: begin
                    if (accept) begin
                        if (sym_type_i == SymBase) begin
                            dbp_cnt_q <= '0;
                            state_q   <= StDbp;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StDbp: begin
                    if (accept) begin
                        if (sym_type_i == SymDbp) begin
                            dbp_cnt_q <= dbp_cnt_q + CW'(1);
                        end else if (sym_type_i == SymZrun) begin
                            dbp_cnt_q <= dbp_cnt_q + CW'(1);
                            if (zlen != '0) begin
                                if (blk_end) begin
                                    err_q <= 1'b1;
                                end else if (32'(zlen) > 32'(rem_after)) begin
                                    err_q   <= 1'b1;
                                    zrem_q  <= ZRUN_W'(rem_after);
                                    state_q <= StZrun;
                                end else begin
                                    zrem_q  <= zlen;
                                    state_q <= StZrun;
                                end
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StZrun: begin
                    if (buf_push_o) begin
                        dbp_cnt_q <= dbp_cnt_q + CW'(1);
                        zrem_q    <= zrem_q - ZRUN_W'(1);
                        if (zrem_q == ZRUN_W'(1)) state_q <= StDbp;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Block completion overrides whatever the per-state logic chose.
            if (blk_end) begin
                blk_cnt_q <= blk_cnt_q - BLK_CNT_W'(1);
                if (blk_cnt_q == BLK_CNT_W'(1)) begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= StBase;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_dbp_buffer_ctrl.sv
// Scoreboard bench for dbp_buffer_ctrl: expected buffer pushes are queued by the stimulus
// and popped by a monitor whenever the DUT pushes.
module tb_dbp_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_blocks = '0;
    logic        clr = 1'b0;
    logic [1:0]  sym_type = '0;
    logic [7:0]  sym_data = '0;
    logic        sym_vld = 1'b0;
    logic        sym_rdy;
    logic [7:0]  buf_data;
    logic        buf_push, buf_vld, buf_clr;
    logic        buf_rdy = 1'b1;
    logic        busy, done, err;

    dbp_buffer_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .num_blocks_i(num_blocks),
        .clr_i       (clr),
        .sym_type_i  (sym_type),
        .sym_data_i  (sym_data),
        .sym_vld_i   (sym_vld),
        .sym_rdy_o   (sym_rdy),
        .buf_data_o  (buf_data),
        .buf_push_o  (buf_push),
        .buf_vld_o   (buf_vld),
        .buf_rdy_i   (buf_rdy),
        .buf_clr_o   (buf_clr),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       vld;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   pending_done = 1'b0;
    bit   rdy_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic exp_push(input logic [7:0] d, input logic vld, input logic last);
        exp_t e;
        e.d = d; e.vld = vld; e.last = last;
        exp_q.push_back(e);
    endtask

    // Monitor: every push must match the head of the scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        if (pending_done) begin
            chk("done_after_last", {31'b0, done}, 32'd1);
            pending_done = 1'b0;
        end
        if (buf_push) begin
            chk("push_while_rdy", {31'b0, buf_rdy}, 32'd1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_push: got data %0h vld %0b expected none", buf_data, buf_vld);
            end else begin
                e = exp_q.pop_front();
                chk("push_data", {24'b0, buf_data}, {24'b0, e.d});
                chk("push_vld", {31'b0, buf_vld}, {31'b0, e.vld});
                if (e.last) pending_done = 1'b1;
            end
        end else if (buf_vld) begin
            chk("vld_without_push", {31'b0, buf_vld}, 32'd0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) buf_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [1:0] t, input logic [7:0] d);
        int n;
        sym_type = t;
        sym_data = d;
        sym_vld  = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (sym_rdy) break;
            n++;
            if (n > 300) begin
                total++;
                bad++;
                $display("FAIL sym_handshake_timeout: got no ready expected ready");
                break;
            end
        end
        @(posedge clk);
        #1 sym_vld = 1'b0;
    endtask

    task automatic start_job(input logic [15:0] n);
        num_blocks = n;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pending_done) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_clr();
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    initial begin
        logic [7:0] blk_b[9];
        blk_b = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'hB0, 8'hB2, 8'hB4, 8'hB6, 8'hB8};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_sym_rdy", {31'b0, sym_rdy}, 32'd0);
        chk("rst_push", {31'b0, buf_push}, 32'd0);

        // Zero-block job completes immediately.
        @(posedge clk);
        #1 start_job(16'd0);
        @(negedge clk);
        chk("zero_job_done", {31'b0, done}, 32'd1);
        chk("zero_job_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("zero_job_done_pulse", {31'b0, done}, 32'd0);

        // Base 0x5A + 9 DBPs.
        @(posedge clk);
        #1 start_job(16'd1);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        exp_push(8'h5A, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) exp_push(8'(i * 16), (i == 9), (i == 9));
        send(2'b00, 8'h5A);
        for (int i = 1; i <= 9; i++) send(2'b01, 8'(i * 16));
        wait_drain();
        chk("t1_busy_end", {31'b0, busy}, 32'd0);
        chk("t1_err", {31'b0, err}, 32'd0);

        // Base + one zero-run of 9.
        start_job(16'd1);
        exp_push(8'h33, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) exp_push(8'h00, (i == 9), (i == 9));
        send(2'b00, 8'h33);
        send(2'b10, 8'h08);
        wait_drain();
        chk("t2_err", {31'b0, err}, 32'd0);
        chk("t2_busy", {31'b0, busy}, 32'd0);

        // Overlong run truncated at block end, then a normal second block.
        start_job(16'd2);
        exp_push(8'h11, 1'b0, 1'b0);
        exp_push(8'h22, 1'b0, 1'b0);
        exp_push(8'h44, 1'b0, 1'b0);
        exp_push(8'h66, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) exp_push(8'h00, (i == 6), 1'b0);
        send(2'b00, 8'h11);
        send(2'b01, 8'h22);
        send(2'b01, 8'h44);
        send(2'b01, 8'h66);
        send(2'b10, 8'h07);
        exp_push(8'h77, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) exp_push(8'(8'h80 + i * 2), (i == 9), (i == 9));
        send(2'b00, 8'h77);
        for (int i = 1; i <= 9; i++) send(2'b01, 8'(8'h80 + i * 2));
        wait_drain();
        chk("t3_err_sticky", {31'b0, err}, 32'd1);

        // Out-of-order DBP in BASE is dropped; following base works.
        do_clr();
        @(negedge clk);
        chk("clr_err_cleared", {31'b0, err}, 32'd0);
        start_job(16'd1);
        send(2'b01, 8'hAA);
        @(negedge clk);
        chk("t6_err", {31'b0, err}, 32'd1);
        chk("t6_no_push_queue", exp_q.size(), 32'd0);
        exp_push(8'hC3, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) exp_push(8'(8'h40 + i * 4), (i == 9), (i == 9));
        send(2'b00, 8'hC3);
        for (int i = 1; i <= 9; i++) send(2'b01, 8'(8'h40 + i * 4));
        wait_drain();
        chk("t6_busy_end", {31'b0, busy}, 32'd0);

        // Three blocks with random buffer back-pressure.
        do_clr();
        start_job(16'd3);
        rdy_rand = 1'b1;
        exp_push(8'h81, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) exp_push(8'(i * 2), (i == 9), 1'b0);
        exp_push(8'h82, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) exp_push(blk_b[i], (i == 8), 1'b0);
        exp_push(8'h83, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) exp_push(8'h00, (i == 9), (i == 9));
        send(2'b00, 8'h81);
        for (int i = 1; i <= 9; i++) send(2'b01, 8'(i * 2));
        send(2'b00, 8'h82);
        send(2'b01, 8'hA0);
        send(2'b10, 8'h02);
        for (int i = 4; i < 9; i++) send(2'b01, blk_b[i]);
        send(2'b00, 8'h83);
        send(2'b10, 8'h08);
        wait_drain();
        rdy_rand = 1'b0;
        @(posedge clk);
        #2 buf_rdy = 1'b1;
        chk("t7_busy_end", {31'b0, busy}, 32'd0);

        // Soft clear in the middle of a zero run.
        start_job(16'd1);
        send(2'b11, 8'h00);
        @(negedge clk);
        chk("t8_err_illegal", {31'b0, err}, 32'd1);
        exp_push(8'h44, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) exp_push(8'(i * 2), 1'b0, 1'b0);
        exp_push(8'h00, 1'b0, 1'b0);
        send(2'b00, 8'h44);
        for (int i = 1; i <= 4; i++) send(2'b01, 8'(i * 2));
        send(2'b10, 8'h04);
        clr = 1'b1;
        @(negedge clk);
        chk("t8_buf_clr", {31'b0, buf_clr}, 32'd1);
        chk("t8_no_push", {31'b0, buf_push}, 32'd0);
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("t8_busy", {31'b0, busy}, 32'd0);
        chk("t8_err", {31'b0, err}, 32'd0);
        chk("t8_buf_clr_off", {31'b0, buf_clr}, 32'd0);
        repeat (6) @(negedge clk);
        chk("t8_queue", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
